rom_arbiter: RTL and testbench



---
 rtl/rom_arbiter.sv | 156 +++++++++++++++
 tb/tb_rom_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares one combinational instruction ROM between the core's fetch port (m0)
// and a secondary read port (m1, used by the loader and debug reads).
// Fetch has fixed priority. A starvation counter forces m1 to win after it has
// been denied STARVE_LIMIT consecutive cycles, so m1 always makes progress.
// The ROM word is captured in a register and returned to the winning master
// one cycle after its grant. A new grant may be made every cycle.
//
// Parameters
//   AW            address width
//   DW            data width
//   STARVE_LIMIT  consecutive denied m1 cycles before m1 is forced (>= 1)
//
// Ports
//   clk                  single clock, rising edge
//   rst                  synchronous, active-high reset
//   m0_req / m0_addr     fetch read request and address
//   m0_gnt               fetch request accepted this cycle
//   m0_rvalid / m0_rdata fetch read response (one-cycle pulse)
//   m1_*                 same set of signals for the secondary master
//   rom_ce / rom_addr    ROM enable and address (address is 0 when idle)
//   rom_data             ROM word, combinational from rom_addr
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          rom_ce,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data
);

    localparam int NM = 2;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;
    logic [DW-1:0] rdata_reg;
    logic          owner_reg;       // id of the master that owns the response
    logic          resp_v_reg;      // a ROM read was issued last cycle

    // Per-master views, indexed by master id (0 = fetch, 1 = secondary)
    logic [NM-1:0] req_vec;
    logic [NM-1:0] gnt_vec;
    logic [NM-1:0] rvalid_vec;
    logic [AW-1:0] addr_vec   [NM];
    logic [AW-1:0] addr_masked[NM];

    logic          force_m1;

    assign req_vec[0]  = m0_req;
    assign req_vec[1]  = m1_req;
    assign addr_vec[0] = m0_addr;
    assign addr_vec[1] = m1_addr;

    // -------------------------------------------------------------------------
    // Grant logic
    // m1 wins whenever fetch is idle, or when it has waited long enough.
    // Both grants are gated by rst so nothing reaches the ROM during reset.
    // -------------------------------------------------------------------------
    assign force_m1   = m1_req && (starve_cnt_reg == LIMIT_C);
    assign gnt_vec[1] = !rst && req_vec[1] && (force_m1 || !req_vec[0]);
    assign gnt_vec[0] = !rst && req_vec[0] && !gnt_vec[1];

    assign m0_gnt = gnt_vec[0];
    assign m1_gnt = gnt_vec[1];

    // -------------------------------------------------------------------------
    // ROM drive: AND-OR mux of the (one-hot or empty) grant vector, so the
    // address collapses to zero when nobody is granted.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_addr_mask
            assign addr_masked[gi] = gnt_vec[gi] ? addr_vec[gi] : '0;
        end
    endgenerate

    assign rom_ce   = |gnt_vec;
    assign rom_addr = addr_masked[0] | addr_masked[1];

    // -------------------------------------------------------------------------
    // Starvation counter next state
    // Counts consecutive cycles in which m1 is requesting but not granted.
    // Any grant to m1, or m1 abandoning its request, restarts the count.
    // -------------------------------------------------------------------------
    always_comb begin
        starve_cnt_next = '0;
        if (m1_req && !gnt_vec[1]) begin
            if (starve_cnt_reg == LIMIT_C) begin
                starve_cnt_next = starve_cnt_reg;
            end else begin
                starve_cnt_next = starve_cnt_reg + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state: starvation counter and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
            rdata_reg      <= '0;
            owner_reg      <= 1'b0;
            resp_v_reg     <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            resp_v_reg     <= rom_ce;
            owner_reg      <= gnt_vec[1];
            // Keep the last word when idle so rdata does not toggle needlessly.
            if (rom_ce) begin
                rdata_reg <= rom_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response routing
    // The register still holds last cycle's issue flag while rst is first
    // asserted; gating with rst drops a response whose grant preceded reset.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NM; gi++) begin : g_rvalid
            assign rvalid_vec[gi] = !rst && resp_v_reg && (owner_reg == 1'(gi));
        end
    endgenerate

    assign m0_rvalid = rvalid_vec[0];
    assign m1_rvalid = rvalid_vec[1];
    assign m0_rdata  = rdata_reg;
    assign m1_rdata  = rdata_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
//
// Self-checking bench for rom_arbiter. The ROM is modelled as a fixed hash of
// the address. A reference model tracks how long m1 has been waiting and which
// master was served last cycle, and a compare process checks every DUT output
// each cycle. Directed sequences add literal expectations for the grant
// patterns, then a randomized phase exercises masters that obey the
// hold-until-grant rule, including occasional abandons and resets.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    rom_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model + compare process
    // denied: consecutive cycles m1 has asked and been refused.
    // prev_id/prev_addr: who was served last cycle (-1 = nobody).
    // -------------------------------------------------------------------------
    int            denied  = 0;
    int            prev_id = -1;
    logic [AW-1:0] prev_addr = '0;
    int            eg;
    logic [AW-1:0] ea;

    always @(negedge clk) begin
        eg = -1;
        if (!rst) begin
            if (m1_req && (!m0_req || denied >= LIM)) eg = 1;
            else if (m0_req)                          eg = 0;
        end
        ea = (eg == 1) ? m1_addr : (eg == 0) ? m0_addr : '0;

        chk("m0_gnt",    64'(m0_gnt),    64'(eg == 0));
        chk("m1_gnt",    64'(m1_gnt),    64'(eg == 1));
        chk("rom_ce",    64'(rom_ce),    64'(eg >= 0));
        chk("rom_addr",  64'(rom_addr),  64'(ea));
        chk("m0_rvalid", 64'(m0_rvalid), 64'(!rst && prev_id == 0));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(!rst && prev_id == 1));
        if (!rst && prev_id == 0) begin
            chk("m0_rdata", 64'(m0_rdata), 64'(rom_fn(prev_addr)));
            $display("rsp m0 addr=%08h data=%08h", prev_addr, m0_rdata);
        end
        if (!rst && prev_id == 1) begin
            chk("m1_rdata", 64'(m1_rdata), 64'(rom_fn(prev_addr)));
            $display("rsp m1 addr=%08h data=%08h", prev_addr, m1_rdata);
        end

        if (rst) begin
            denied  = 0;
            prev_id = -1;
        end else begin
            if (m1_req && eg != 1) denied = (denied < LIM) ? denied + 1 : LIM;
            else                   denied = 0;
            prev_id   = eg;
            prev_addr = ea;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic          g0, g1, rv0, rv1;
    logic [DW-1:0] rd0;

    task automatic cyc(input logic r, input logic q0, input logic [AW-1:0] a0,
                       input logic q1, input logic [AW-1:0] a1);
        @(posedge clk);
        #1;
        rst = r; m0_req = q0; m0_addr = a0; m1_req = q1; m1_addr = a1;
        @(negedge clk);
        #1;
        g0 = m0_gnt; g1 = m1_gnt; rv0 = m0_rvalid; rv1 = m1_rvalid; rd0 = m0_rdata;
    endtask

    initial begin
        logic [9:0] pat;
        int         first;
        logic       q0, q1;
        logic [AW-1:0] a0, a1;

        // Reset held 3 cycles with both masters requesting.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 32'h10, 1'b1, 32'h20);
            chk("rst_no_gnt", 64'({g0, g1, rom_ce}), 64'd0);
        end
        cyc(1'b0, 1'b0, '0, 1'b0, '0);
        chk("post_rst_outs", 64'({g0, g1, rv0, rv1, rom_ce}), 64'd0);
        chk("post_rst_rdata", 64'(rd0), 64'd0);
        chk("post_rst_addr", 64'(rom_addr), 64'd0);

        // m0 only, addresses 0, 4, 8.
        cyc(1'b0, 1'b1, 32'd0, 1'b0, '0);
        chk("m0_seq_gnt0", 64'(g0), 64'd1);
        cyc(1'b0, 1'b1, 32'd4, 1'b0, '0);
        chk("m0_seq_rv0", 64'({rv0, rv1}), 64'b10);
        chk("m0_rom0_lit", 64'(rd0), 64'hA5A5_0F0F);
        cyc(1'b0, 1'b1, 32'd8, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b0, '0);
        chk("m0_seq_last_rv", 64'({rv0, rv1}), 64'b10);

        // Both requesting continuously: m0 x4, then m1, repeating.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
            pat[i] = g1;
            chk("both_one_gnt", 64'(g0 ^ g1), 64'd1);
        end
        chk("both_pattern", 64'(pat), 64'h210);

        // m1 asks 2 cycles, abandons, then re-asks: counter restarts at 0.
        cyc(1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 32'h44, 1'b1, 32'h104);
            chk("starve_pre_deny", 64'(g1), 64'd0);
        end
        cyc(1'b0, 1'b1, 32'h44, 1'b0, '0);
        first = -1;
        for (int i = 0; i < 6 && first < 0; i++) begin
            cyc(1'b0, 1'b1, 32'h48, 1'b1, 32'h108);
            if (g1) first = i;
        end
        chk("starve_restart_idx", 64'(first), 64'd4);

        // Interleaved single-master cycles.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                cyc(1'b0, 1'b0, '0, 1'b1, 32'h200 + 32'(i));
                chk("ilv_m1_gnt", 64'({g0, g1}), 64'b01);
            end else begin
                cyc(1'b0, 1'b1, 32'h300 + 32'(i), 1'b0, '0);
                chk("ilv_m0_gnt", 64'({g0, g1}), 64'b10);
                chk("ilv_m1_rv", 64'({rv0, rv1}), 64'b01);
            end
        end

        // Reset right after an m1 grant: response suppressed, counter cleared.
        cyc(1'b0, 1'b1, 32'h50, 1'b1, 32'h110);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h114);
        chk("pre_rst_m1_gnt", 64'(g1), 64'd1);
        cyc(1'b1, 1'b1, 32'h50, 1'b1, 32'h118);
        chk("rst_kills_rv1", 64'({rv0, rv1}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 32'h54, 1'b1, 32'h118);
            pat[i] = g1;
        end
        chk("post_rst_pattern", 64'(pat[4:0]), 64'h10);

        // Randomized masters obeying hold-until-grant.
        q0 = 1'b0; q1 = 1'b0; a0 = '0; a1 = '0;
        for (int i = 0; i < 600; i++) begin
            if (q0 && !g0 && $urandom_range(0, 9) != 0) begin
                // hold
            end else begin
                q0 = ($urandom_range(0, 3) != 0);
                a0 = $urandom;
            end
            if (q1 && !g1 && $urandom_range(0, 9) != 0) begin
                // hold
            end else begin
                q1 = ($urandom_range(0, 2) != 0);
                a1 = $urandom;
            end
            cyc(($urandom_range(0, 99) == 0), q0, a0, q1, a1);
        end

        cyc(1'b0, 1'b0, '0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
